// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and a level irq.
// Optional TIMER_PRESCALE_EN adds an 8-bit prescaler in CTRL[11:4].
module timer_dev #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:2]       addr,
    input  logic             we,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    output logic             irq,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_next;
    logic             r_enable, r_im, r_pend;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_preset, r_count;
    logic             w_wr_ctrl, w_wr_preset, w_tick;
    logic             w_load, w_dec, w_set_pend, w_clr_pend, w_clr_en;
    logic             w_unused;

    assign w_wr_ctrl   = we && (addr == 2'd0);
    assign w_wr_preset = we && (addr == 2'd1);

`ifdef TIMER_PRESCALE_EN
    logic [7:0] r_scale, r_pcnt;
    // Counting down from S means the first CNT cycle after LOAD is a tick.
    assign w_tick   = (r_pcnt == 8'd0);
    assign w_unused = ^din[31:12];
`else
    assign w_tick   = 1'b1;
    assign w_unused = ^din[31:4];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_dec      = 1'b0;
        w_set_pend = 1'b0;
        w_clr_pend = 1'b0;
        w_clr_en   = 1'b0;
        case (r_state)
            S_IDLE: if (r_enable) w_next = S_LOAD;
            S_LOAD: begin
                w_load = 1'b1;
                w_next = S_CNT;
            end
            S_CNT: begin
                if (!r_enable) begin
                    w_next = S_IDLE;
                end else if (w_tick) begin
                    if (r_count != '0) begin
                        w_dec = 1'b1;
                    end else begin
                        w_set_pend = 1'b1;
                        w_next     = S_INT;
                    end
                end
            end
            S_INT: begin
                if (r_mode == 2'b01) begin
                    w_clr_pend = 1'b1;
                    w_next     = S_LOAD;
                end else begin
                    w_clr_en = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // A CPU write to CTRL overrides the one-shot clear of Enable on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable <= 1'b0;
            r_mode   <= 2'b00;
            r_im     <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_enable <= din[0];
            r_mode   <= din[2:1];
            r_im     <= din[3];
        end else if (w_clr_en) begin
            r_enable <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_preset <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_preset) r_preset <= din[CNT_W-1:0];
            if (w_load)      r_count  <= r_preset;
            else if (w_dec)  r_count  <= r_count - ONE;
        end
    end

    // The FSM set beats a CPU clear so an expiring count is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       r_pend <= 1'b0;
        else if (w_set_pend)                              r_pend <= 1'b1;
        else if (w_wr_ctrl || w_wr_preset || w_clr_pend)  r_pend <= 1'b0;
    end

`ifdef TIMER_PRESCALE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scale <= 8'd0;
            r_pcnt  <= 8'd0;
        end else begin
            if (w_wr_ctrl) r_scale <= din[11:4];
            if (w_load || !r_enable)  r_pcnt <= 8'd0;
            else if (r_state == S_CNT) r_pcnt <= w_tick ? r_scale : r_pcnt - 8'd1;
        end
    end
`endif

    always_comb begin
        dout = '0;
        case (addr)
`ifdef TIMER_PRESCALE_EN
            2'd0: dout[11:0] = {r_scale, r_im, r_mode, r_enable};
`else
            2'd0: dout[3:0] = {r_im, r_mode, r_enable};
`endif
            2'd1: dout[CNT_W-1:0] = r_preset;
            2'd2: dout[CNT_W-1:0] = r_count;
            default: dout = '0;
        endcase
    end

    assign irq         = r_im & r_pend;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: register vectors from a table, then timed
// one-shot, auto-reload, masking, disable, collision and reset sequences.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] A_CTRL = 2'd0, A_PRESET = 2'd1, A_COUNT = 2'd2, A_RSVD = 2'd3;
  localparam logic [31:0] ST_IDLE = 32'd0, ST_LOAD = 32'd1, ST_CNT = 32'd2, ST_INT = 32'd3;

  typedef struct {
    logic        do_wr;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  always #10 clk = ~clk;

  timer_dev #(.CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr        (addr),
    .we          (we),
    .din         (din),
    .dout        (dout),
    .irq         (irq),
    .o_dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive on the falling edge so the write lands on the next rising edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we  = 1'b0;
    din = 32'd0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, dout, exp);
  endtask

  task automatic stop_timer();
    bus_write(A_CTRL, 32'd0);
    tick(4);
  endtask

  initial begin
    rst_n = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    din   = 32'd0;

    vecs[0] = '{1'b1, A_PRESET, 32'h1234_5678, A_PRESET, 32'h1234_5678};
    vecs[1] = '{1'b1, A_CTRL,   32'hFFFF_FFF6, A_CTRL,   32'h0000_0006};
    vecs[2] = '{1'b1, A_CTRL,   32'h0000_000A, A_CTRL,   32'h0000_000A};
    vecs[3] = '{1'b1, A_RSVD,   32'h0000_DEAD, A_RSVD,   32'h0000_0000};
    vecs[4] = '{1'b1, A_COUNT,  32'h0000_0055, A_COUNT,  32'h0000_0000};
    vecs[5] = '{1'b0, A_CTRL,   32'h0000_0000, A_PRESET, 32'h1234_5678};
    vecs[6] = '{1'b1, A_CTRL,   32'h0000_0FF0, A_CTRL,   32'h0000_0000};
    vecs[7] = '{1'b1, A_PRESET, 32'h0000_0000, A_PRESET, 32'h0000_0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, ST_IDLE);
    check_rd("rst_ctrl", A_CTRL, 32'd0);
    check_rd("rst_preset", A_PRESET, 32'd0);
    check_rd("rst_count", A_COUNT, 32'd0);
    check_rd("rst_rsvd", A_RSVD, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Register access table, Enable kept 0 throughout
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].wa, vecs[i].wd);
      check_rd($sformatf("reg_vec[%0d]", i), vecs[i].ra, vecs[i].exp);
    end
    check("reg_vec_state", {30'd0, dbg_state}, ST_IDLE);

    // One-shot, P=5
    bus_write(A_PRESET, 32'd5);
    bus_write(A_CTRL, 32'h9);
    tick(1);
    check("os_e1_state", {30'd0, dbg_state}, ST_LOAD);
    tick(1);
    check_rd("os_e2_count", A_COUNT, 32'd5);
    check("os_e2_state", {30'd0, dbg_state}, ST_CNT);
    tick(5);
    check_rd("os_e7_count", A_COUNT, 32'd0);
    check("os_e7_irq", {31'd0, irq}, 32'd0);
    tick(1);
    check("os_e8_irq", {31'd0, irq}, 32'd1);
    check("os_e8_state", {30'd0, dbg_state}, ST_INT);
    tick(1);
    check_rd("os_e9_ctrl", A_CTRL, 32'h8);
    check("os_e9_state", {30'd0, dbg_state}, ST_IDLE);
    tick(3);
    check("os_irq_held", {31'd0, irq}, 32'd1);
    bus_write(A_CTRL, 32'h8);
    check("os_clear_irq", {31'd0, irq}, 32'd0);
    stop_timer();

    // Auto-reload, P=5: period 8, one-cycle pulses
    bus_write(A_PRESET, 32'd5);
    bus_write(A_CTRL, 32'hB);
    for (int k = 1; k <= 26; k++) begin
      tick(1);
      check($sformatf("ar_irq_e%0d", k), {31'd0, irq}, (k % 8 == 0) ? 32'd1 : 32'd0);
      if (k == 10) check_rd("ar_e10_count", A_COUNT, 32'd5);
    end
    stop_timer();

    // Masked zero preset: pend is set but irq stays 0, and a CTRL write clears pend
    bus_write(A_PRESET, 32'd0);
    bus_write(A_CTRL, 32'h1);
    tick(3);
    check("mask_e3_state", {30'd0, dbg_state}, ST_INT);
    check("mask_e3_irq", {31'd0, irq}, 32'd0);
    tick(1);
    check_rd("mask_e4_ctrl", A_CTRL, 32'h0);
    bus_write(A_CTRL, 32'h8);
    check("mask_im_irq", {31'd0, irq}, 32'd0);
    stop_timer();

    // Zero preset unmasked: irq at E3
    bus_write(A_CTRL, 32'h9);
    tick(2);
    check("zp_e2_irq", {31'd0, irq}, 32'd0);
    tick(1);
    check("zp_e3_irq", {31'd0, irq}, 32'd1);
    stop_timer();

    // Disable during CNT: the edge writing Enable=0 still decrements 4->3, then COUNT holds
    bus_write(A_PRESET, 32'd5);
    bus_write(A_CTRL, 32'h9);
    tick(3);
    check_rd("dis_e3_count", A_COUNT, 32'd4);
    bus_write(A_CTRL, 32'h8);
    check_rd("dis_e4_count", A_COUNT, 32'd3);
    tick(1);
    check("dis_state", {30'd0, dbg_state}, ST_IDLE);
    tick(3);
    check_rd("dis_count_held", A_COUNT, 32'd3);
    check("dis_irq", {31'd0, irq}, 32'd0);

    // PRESET write on the CNT->INT edge: set of irq_pend wins
    bus_write(A_PRESET, 32'd2);
    bus_write(A_CTRL, 32'h9);
    tick(4);
    check("setwin_e4_irq", {31'd0, irq}, 32'd0);
    bus_write(A_PRESET, 32'd7);
    check("setwin_e5_irq", {31'd0, irq}, 32'd1);
    check("setwin_e5_state", {30'd0, dbg_state}, ST_INT);
    stop_timer();

    // CTRL write on the one-shot INT edge: CPU Enable wins, timer restarts
    bus_write(A_PRESET, 32'd2);
    bus_write(A_CTRL, 32'h9);
    tick(5);
    check("col_e5_irq", {31'd0, irq}, 32'd1);
    bus_write(A_CTRL, 32'h9);
    check_rd("col_e6_ctrl", A_CTRL, 32'h9);
    check("col_e6_state", {30'd0, dbg_state}, ST_IDLE);
    check("col_e6_irq", {31'd0, irq}, 32'd0);
    tick(1);
    check("col_e7_state", {30'd0, dbg_state}, ST_LOAD);
    tick(1);
    check_rd("col_e8_count", A_COUNT, 32'd2);
    tick(2);
    check("col_e10_irq", {31'd0, irq}, 32'd0);
    tick(1);
    check("col_e11_irq", {31'd0, irq}, 32'd1);
    stop_timer();

    // Reset mid-operation with irq high: drops without a clock edge
    bus_write(A_PRESET, 32'd3);
    bus_write(A_CTRL, 32'h9);
    tick(6);
    check("rm_irq_before", {31'd0, irq}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rm_irq", {31'd0, irq}, 32'd0);
    check("rm_state", {30'd0, dbg_state}, ST_IDLE);
    check_rd("rm_ctrl", A_CTRL, 32'd0);
    check_rd("rm_preset", A_PRESET, 32'd0);
    check_rd("rm_count", A_COUNT, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    check("rm_post_state", {30'd0, dbg_state}, ST_IDLE);
    check("rm_post_irq", {31'd0, irq}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
